// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and helpers for the image loader.
// Holds the FSM state encoding, byte-strobe constants and the
// lane-to-strobe mapping used by the packer and the top level.
package mem_loader_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        HDR0  = 4'd1,
        HDR1  = 4'd2,
        HDR2  = 4'd3,
        HDR3  = 4'd4,
        LOAD  = 4'd5,
        FLUSH = 4'd6,
        DONE  = 4'd7,
        ERR   = 4'd8
    } state_t;

    // Filled-lane masks: STRB_n means lanes 0..n-1 hold valid bytes.
    localparam logic [3:0] STRB_1 = 4'b0001;
    localparam logic [3:0] STRB_2 = 4'b0011;
    localparam logic [3:0] STRB_3 = 4'b0111;
    localparam logic [3:0] STRB_4 = 4'b1111;

    // Lane of the word-completing byte -> mask of all lanes filled so far.
    function automatic logic [3:0] laneToStrb(input logic [1:0] lane);
        logic [3:0] strb;
        case (lane)
            2'd0:    strb = STRB_1;
            2'd1:    strb = STRB_2;
            2'd2:    strb = STRB_3;
            default: strb = STRB_4;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream input plus memory-write / core-control bus.
// master = the loader (sinks the stream, drives writes and status);
// slave  = the environment (byte source, memory, core).
interface mem_loader_if;

    logic [7:0]  wInData;
    logic        wInValid;
    logic        wInReady;
    logic [31:0] wWriteAddr;
    logic [31:0] wWriteData;
    logic [3:0]  wWstrb;
    logic        wnCoreRst;
    logic        wDone;
    logic        wError;
    logic [31:0] wByteCount;

    modport master (
        input  wInData, wInValid,
        output wInReady, wWriteAddr, wWriteData, wWstrb,
               wnCoreRst, wDone, wError, wByteCount
    );

    modport slave (
        output wInData, wInValid,
        input  wInReady, wWriteAddr, wWriteData, wWstrb,
               wnCoreRst, wDone, wError, wByteCount
    );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// byte_packer: assembles payload bytes little-endian into a 32-bit word.
// Latency: word/strobe/wordVld are combinational with the completing byte.
// Backpressure: none; it consumes whatever the top accepts (inVld).
// Ports: wClk, wnRst; inVld/inByte/lane/last in; word/strb/wordVld out.
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic        wClk,
    input  logic        wnRst,
    input  logic        inVld,
    input  logic [7:0]  inByte,
    input  logic [1:0]  lane,
    input  logic        last,
    output logic [31:0] word,
    output logic [3:0]  strb,
    output logic        wordVld
);

    logic [31:0] bufQ;

    // Lanes above the current one are still zero because the buffer
    // is cleared after every emitted word, so unfilled lanes read 0.
    always_comb begin
        word = bufQ;
        word[8*lane +: 8] = inByte;
    end

    assign strb    = laneToStrb(lane);
    assign wordVld = inVld && ((lane == 2'd3) || last);

    always_ff @(posedge wClk or negedge wnRst) begin
        if (!wnRst) begin
            bufQ <= '0;
        end else if (wordVld) begin
            bufQ <= '0;
        end else if (inVld) begin
            bufQ <= word;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: receives length-prefixed byte image, writes it to memory, then releases core reset.
// Latency: one write strobe the cycle after each word completes; core leaves reset one cycle after the last strobe.
// Backpressure: wInReady high in HDR0..HDR3/LOAD only, never drops inside LOAD (one byte per cycle).
// Ports: wClk, wnRst; bus (mem_loader_if.master) carries stream in, write bus and status out.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_BYTES = 65536
)
(
    input  logic          wClk,
    input  logic          wnRst,
    mem_loader_if.master  bus
);

    if (BASE_ADDR[1:0] != 2'b00) begin : gBadBase
        $error("mem_loader: BASE_ADDR must be 4-byte aligned");
    end
    if (MAX_BYTES == 0) begin : gBadMax
        $error("mem_loader: MAX_BYTES must be at least 1");
    end

    state_t      state, nextState;
    logic [31:0] lenReg;
    logic [31:0] byteCnt;
    logic        inReadyQ, nextReady;
    logic        doneQ, nextDone;
    logic        errQ, nextErr;
    logic        coreRstNQ, nextCoreRstN;
    logic [31:0] addrQ, dataQ;
    logic [3:0]  strbQ;

    logic        accept, payAccept, lastByte;
    logic [31:0] hdrLen;
    logic [31:0] pkWord;
    logic [3:0]  pkStrb;
    logic        pkVld;

    // wInReady mirrors the state, so accept implies an accepting state.
    assign accept    = bus.wInValid && inReadyQ;
    assign payAccept = accept && (state == LOAD);
    // Full length as seen while the top header byte is on the bus.
    assign hdrLen    = {bus.wInData, lenReg[23:0]};
    assign lastByte  = (byteCnt + 32'd1) == lenReg;

    byte_packer uPacker (
        .wClk    (wClk),
        .wnRst   (wnRst),
        .inVld   (payAccept),
        .inByte  (bus.wInData),
        .lane    (byteCnt[1:0]),
        .last    (lastByte),
        .word    (pkWord),
        .strb    (pkStrb),
        .wordVld (pkVld)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  nextState = HDR0;
            HDR0:  if (accept) nextState = HDR1;
            HDR1:  if (accept) nextState = HDR2;
            HDR2:  if (accept) nextState = HDR3;
            HDR3:  if (accept) begin
                       if (hdrLen == 32'd0)          nextState = DONE;
                       else if (hdrLen > MAX_BYTES)  nextState = ERR;
                       else                          nextState = LOAD;
                   end
            LOAD:  if (payAccept && lastByte) nextState = FLUSH;
            FLUSH: nextState = DONE;
            DONE:  nextState = DONE;
            ERR:   nextState = ERR;
            default: nextState = IDLE;
        endcase

        // Status outputs are registered from the next state so they line
        // up with the state they describe.
        nextReady    = (nextState == HDR0) || (nextState == HDR1) ||
                       (nextState == HDR2) || (nextState == HDR3) ||
                       (nextState == LOAD);
        nextDone     = (nextState == DONE);
        nextErr      = (nextState == ERR);
        nextCoreRstN = (nextState == DONE);
    end

    always_ff @(posedge wClk or negedge wnRst) begin
        if (!wnRst) begin
            state     <= IDLE;
            lenReg    <= '0;
            byteCnt   <= '0;
            inReadyQ  <= 1'b0;
            doneQ     <= 1'b0;
            errQ      <= 1'b0;
            coreRstNQ <= 1'b0;
            addrQ     <= '0;
            dataQ     <= '0;
            strbQ     <= '0;
        end else begin
            state     <= nextState;
            inReadyQ  <= nextReady;
            doneQ     <= nextDone;
            errQ      <= nextErr;
            coreRstNQ <= nextCoreRstN;

            if (accept) begin
                case (state)
                    HDR0: lenReg[7:0]   <= bus.wInData;
                    HDR1: lenReg[15:8]  <= bus.wInData;
                    HDR2: lenReg[23:16] <= bus.wInData;
                    HDR3: lenReg        <= hdrLen;
                    default: ;
                endcase
            end

            if (payAccept) byteCnt <= byteCnt + 32'd1;

            // One-cycle strobe; address/data hold until the next word.
            strbQ <= pkVld ? pkStrb : 4'b0000;
            if (pkVld) begin
                addrQ <= BASE_ADDR + {byteCnt[31:2], 2'b00};
                dataQ <= pkWord;
            end
        end
    end

    assign bus.wInReady   = inReadyQ;
    assign bus.wWriteAddr = addrQ;
    assign bus.wWriteData = dataQ;
    assign bus.wWstrb     = strbQ;
    assign bus.wnCoreRst  = coreRstNQ;
    assign bus.wDone      = doneQ;
    assign bus.wError     = errQ;
    assign bus.wByteCount = byteCnt;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: self-checking bench for mem_loader.
// Table of length/payload vectors with expected writes, plus hand
// sequences for zero length, overflow, stream gaps and mid-load reset.
module tb_mem_loader;

    localparam logic [31:0] BASE = 32'h8000_0100;
    localparam int unsigned MAXB = 65536;

    logic wClk  = 1'b0;
    logic wnRst = 1'b0;

    mem_loader_if bus();

    mem_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
        .wClk  (wClk),
        .wnRst (wnRst),
        .bus   (bus)
    );

    always #5 wClk = ~wClk;

    int nCmp = 0;
    int nErr = 0;

    // Write monitor: logs every strobe and the cycle of each core-reset release.
    int          cyc = 0;
    int          nW = 0;
    int          riseCyc = -1;
    logic        prevCore = 1'b0;
    logic [31:0] logAddr [64];
    logic [31:0] logData [64];
    logic [3:0]  logStrb [64];
    int          logCyc  [64];

    always @(negedge wClk) begin
        if (bus.wWstrb != 4'h0 && nW < 64) begin
            logAddr[nW] = bus.wWriteAddr;
            logData[nW] = bus.wWriteData;
            logStrb[nW] = bus.wWstrb;
            logCyc[nW]  = cyc;
            nW++;
        end
        if (bus.wnCoreRst && !prevCore) riseCyc = cyc;
        prevCore = bus.wnCoreRst;
        cyc++;
    end

    typedef struct {
        logic [31:0] len;
        logic [63:0] pay;
        int          nw;
        logic [31:0] d0;
        logic [3:0]  s0;
        logic [31:0] d1;
        logic [3:0]  s1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int g;
        g = 0;
        bus.wInData  = b;
        bus.wInValid = 1'b1;
        @(negedge wClk);
        while (!bus.wInReady && g < 20) begin
            @(negedge wClk);
            g++;
        end
        if (!bus.wInReady) check("rdyWait", 32'(bus.wInReady), 32'd1);
        @(posedge wClk);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8]);
    endtask

    task automatic checkResetOuts(input string tag);
        check({tag, "_rdy"},   32'(bus.wInReady),  32'd0);
        check({tag, "_strb"},  32'(bus.wWstrb),    32'd0);
        check({tag, "_addr"},  bus.wWriteAddr,     32'd0);
        check({tag, "_data"},  bus.wWriteData,     32'd0);
        check({tag, "_core"},  32'(bus.wnCoreRst), 32'd0);
        check({tag, "_done"},  32'(bus.wDone),     32'd0);
        check({tag, "_err"},   32'(bus.wError),    32'd0);
        check({tag, "_count"}, bus.wByteCount,     32'd0);
    endtask

    task automatic doReset();
        bus.wInValid = 1'b0;
        bus.wInData  = 8'h00;
        @(negedge wClk);
        wnRst = 1'b0;
        @(negedge wClk);
        checkResetOuts("rst");
        wnRst = 1'b1;
    endtask

    task automatic waitFinish();
        int g;
        g = 0;
        while (!(bus.wDone || bus.wError) && g < 40) begin
            @(negedge wClk);
            g++;
        end
        check("finishWait", 32'(bus.wDone | bus.wError), 32'd1);
    endtask

    task automatic runVec(input int i);
        int b0;
        doReset();
        b0 = nW;
        sendWord(vecs[i].len);
        for (int k = 0; k < int'(vecs[i].len); k++) sendByte(vecs[i].pay[8*k +: 8]);
        bus.wInValid = 1'b0;
        waitFinish();
        repeat (3) @(negedge wClk);
        check($sformatf("v%0d_nWrites", i), 32'(nW - b0), 32'(vecs[i].nw));
        if (vecs[i].nw >= 1 && nW - b0 >= 1) begin
            check($sformatf("v%0d_addr0", i), logAddr[b0], BASE);
            check($sformatf("v%0d_data0", i), logData[b0], vecs[i].d0);
            check($sformatf("v%0d_strb0", i), 32'(logStrb[b0]), 32'(vecs[i].s0));
        end
        if (vecs[i].nw == 2 && nW - b0 >= 2) begin
            check($sformatf("v%0d_addr1", i), logAddr[b0+1], BASE + 32'd4);
            check($sformatf("v%0d_data1", i), logData[b0+1], vecs[i].d1);
            check($sformatf("v%0d_strb1", i), 32'(logStrb[b0+1]), 32'(vecs[i].s1));
            check($sformatf("v%0d_strbGap", i), 32'(logCyc[b0+1] - logCyc[b0]), vecs[i].len - 32'd4);
        end
        if (vecs[i].nw >= 1 && nW - b0 >= vecs[i].nw)
            check($sformatf("v%0d_coreRise", i), 32'(riseCyc), 32'(logCyc[b0 + vecs[i].nw - 1] + 1));
        check($sformatf("v%0d_done", i),  32'(bus.wDone),     32'd1);
        check($sformatf("v%0d_err", i),   32'(bus.wError),    32'd0);
        check($sformatf("v%0d_core", i),  32'(bus.wnCoreRst), 32'd1);
        check($sformatf("v%0d_rdy", i),   32'(bus.wInReady),  32'd0);
        check($sformatf("v%0d_count", i), bus.wByteCount,     vecs[i].len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int bad;
        logic [7:0] gapBytes [4];

        bus.wInValid = 1'b0;
        bus.wInData  = 8'h00;

        vecs[0] = '{len: 32'd8, pay: 64'h8877_6655_4433_2211, nw: 2,
                    d0: 32'h4433_2211, s0: 4'hF, d1: 32'h8877_6655, s1: 4'hF};
        vecs[1] = '{len: 32'd6, pay: 64'h0000_FFEE_DDCC_BBAA, nw: 2,
                    d0: 32'hDDCC_BBAA, s0: 4'hF, d1: 32'h0000_FFEE, s1: 4'b0011};
        vecs[2] = '{len: 32'd0, pay: 64'h0, nw: 0,
                    d0: 32'h0, s0: 4'h0, d1: 32'h0, s1: 4'h0};
        vecs[3] = '{len: 32'd1, pay: 64'h5A, nw: 1,
                    d0: 32'h0000_005A, s0: 4'b0001, d1: 32'h0, s1: 4'h0};
        vecs[4] = '{len: 32'd3, pay: 64'h03_0201, nw: 1,
                    d0: 32'h0003_0201, s0: 4'b0111, d1: 32'h0, s1: 4'h0};
        vecs[5] = '{len: 32'd5, pay: 64'h55_4433_2211, nw: 2,
                    d0: 32'h4433_2211, s0: 4'hF, d1: 32'h0000_0055, s1: 4'b0001};

        for (int i = 0; i < 6; i++) runVec(i);

        // Zero length: done and core released right after the last header byte.
        doReset();
        b0 = nW;
        sendWord(32'd0);
        @(negedge wClk);
        check("zero_done", 32'(bus.wDone),     32'd1);
        check("zero_core", 32'(bus.wnCoreRst), 32'd1);
        check("zero_rdy",  32'(bus.wInReady),  32'd0);
        check("zero_nW",   32'(nW - b0),       32'd0);

        // Length exactly MAX_BYTES is accepted and enters the payload phase.
        doReset();
        sendWord(MAXB);
        bus.wInValid = 1'b0;
        @(negedge wClk);
        check("max_rdy", 32'(bus.wInReady), 32'd1);
        check("max_err", 32'(bus.wError),   32'd0);

        // Length MAX_BYTES+1: error, stream ignored for 100 cycles.
        doReset();
        b0 = nW;
        sendWord(MAXB + 1);
        bus.wInData = 8'hA5;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge wClk);
            if (bus.wWstrb != 4'h0 || bus.wInReady || bus.wnCoreRst || !bus.wError) bad++;
        end
        bus.wInValid = 1'b0;
        check("ovf_badCycles", 32'(bad), 32'd0);
        check("ovf_err",   32'(bus.wError),    32'd1);
        check("ovf_done",  32'(bus.wDone),     32'd0);
        check("ovf_count", bus.wByteCount,     32'd0);
        check("ovf_nW",    32'(nW - b0),       32'd0);

        // L=4 with two idle cycles between bytes: single write, no gap strobes.
        gapBytes[0] = 8'h10; gapBytes[1] = 8'h20; gapBytes[2] = 8'h30; gapBytes[3] = 8'h40;
        doReset();
        b0 = nW;
        sendWord(32'd4);
        for (int k = 0; k < 4; k++) begin
            sendByte(gapBytes[k]);
            bus.wInValid = 1'b0;
            repeat (2) @(posedge wClk);
            #1;
        end
        waitFinish();
        repeat (2) @(negedge wClk);
        check("gap_nW", 32'(nW - b0), 32'd1);
        if (nW - b0 >= 1) begin
            check("gap_addr", logAddr[b0], BASE);
            check("gap_data", logData[b0], 32'h4030_2010);
            check("gap_strb", 32'(logStrb[b0]), 32'hF);
        end
        check("gap_done", 32'(bus.wDone), 32'd1);

        // Reset after three payload bytes of L=8: partial word dropped.
        doReset();
        b0 = nW;
        sendWord(32'd8);
        sendByte(8'hC1);
        sendByte(8'hC2);
        sendByte(8'hC3);
        wnRst = 1'b0;
        #1;
        checkResetOuts("midRst");
        bus.wInValid = 1'b0;
        repeat (3) @(negedge wClk);
        check("midRst_nW", 32'(nW - b0), 32'd0);
        // Fresh single-byte load: stale lanes would show up in the word.
        runVec(3);
        runVec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
